event_timestamper_mc: RTL and testbench

- Next-generation event timestamper that measures start-to-end latency for up to 2^ID_W concurrently outstanding IDs.
- Adds an output FIFO with backpressure, a round-robin timeout scanner, and orphan-end detection.
- Sits between packet ingress/egress event taps and the timestamp record sink. Shares the free-running cycle counter convention of the first-generation timestamper.

---
 rtl/event_timestamper_mc.sv | 159 +++++++++++++++
 tb/tb_event_timestamper_mc.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_timestamper_mc.sv
// Multi-ID start/end latency timestamper with output FIFO, timeout scanner and orphan-end detection.
// Optional 16-bit saturating per-status record counters when EV_TIMER_STATS_EN is defined.
module event_timestamper_mc #(
    parameter int unsigned ID_W      = 3,
    parameter int unsigned TS_W      = 8,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [ID_W-1:0] start_id,
    input  logic            end_valid,
    output logic            end_ready,
    input  logic [ID_W-1:0] end_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic [TS_W-1:0] out_start_ts,
    output logic [TS_W-1:0] out_end_ts,
    output logic [TS_W-1:0] out_ts,
    output logic [1:0]      out_status
`ifdef EV_TIMER_STATS_EN
    ,
    output logic [15:0]     stat_ok_cnt,
    output logic [15:0]     stat_timeout_cnt,
    output logic [15:0]     stat_orphan_cnt
`endif
);
    localparam int unsigned N_ID  = 1 << ID_W;
    localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_ORPHAN  = 2'd2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] start_ts;
        logic [TS_W-1:0] end_ts;
        logic [1:0]      status;
    } rec_t;

    logic [TS_W-1:0]  cnt_q;
    logic [N_ID-1:0]  active_q, active_d;
    logic [TS_W-1:0]  start_ts_q [N_ID];
    rec_t             fifo_q [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ID_W-1:0]  scan_ptr_q;

    logic fifo_full, start_hs, end_hs, pop, push, scan_adv, scan_hit;
    rec_t push_rec;

    assign fifo_full   = (count_q == CNT_W'(OUT_DEPTH));
    assign start_ready = !rst && !(end_valid && (end_id == start_id));
    assign end_ready   = !rst && !fifo_full;
    assign start_hs    = start_valid && start_ready;
    assign end_hs      = end_valid && end_ready;
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign push        = end_hs || scan_hit;

    // Scanner stalls on an end handshake or a full FIFO; a same-cycle start on the scanned ID masks it.
    always_comb begin
        scan_adv = 1'b0;
        scan_hit = 1'b0;
        if ((TIMEOUT != 0) && !end_hs && !fifo_full) begin
            scan_adv = 1'b1;
            if (!(start_hs && (start_id == scan_ptr_q)) && active_q[scan_ptr_q] &&
                (TS_W'(cnt_q - start_ts_q[scan_ptr_q]) >= TS_W'(TIMEOUT))) begin
                scan_hit = 1'b1;
            end
        end
    end

    always_comb begin
        push_rec = '0;
        if (end_hs) begin
            push_rec.id     = end_id;
            push_rec.end_ts = cnt_q;
            if (active_q[end_id]) begin
                push_rec.start_ts = start_ts_q[end_id];
                push_rec.status   = ST_OK;
            end else begin
                push_rec.status   = ST_ORPHAN;
            end
        end else begin
            push_rec.id       = scan_ptr_q;
            push_rec.start_ts = start_ts_q[scan_ptr_q];
            push_rec.end_ts   = cnt_q;
            push_rec.status   = ST_TIMEOUT;
        end
    end

    always_comb begin
        active_d = active_q;
        if (start_hs) active_d[start_id]   = 1'b1;
        if (end_hs)   active_d[end_id]     = 1'b0;
        if (scan_hit) active_d[scan_ptr_q] = 1'b0;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            active_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            scan_ptr_q <= '0;
            for (int i = 0; i < int'(N_ID); i++)      start_ts_q[i] <= '0;
            for (int i = 0; i < int'(OUT_DEPTH); i++) fifo_q[i]     <= '0;
        end else begin
            cnt_q    <= cnt_q + TS_W'(1);
            active_q <= active_d;
            count_q  <= count_d;
            if (start_hs) start_ts_q[start_id] <= cnt_q;
            if (push) begin
                fifo_q[wr_ptr_q] <= push_rec;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop)      rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            if (scan_adv) scan_ptr_q <= scan_ptr_q + ID_W'(1);
        end
    end

    assign out_id       = fifo_q[rd_ptr_q].id;
    assign out_start_ts = fifo_q[rd_ptr_q].start_ts;
    assign out_end_ts   = fifo_q[rd_ptr_q].end_ts;
    assign out_ts       = fifo_q[rd_ptr_q].end_ts - fifo_q[rd_ptr_q].start_ts;
    assign out_status   = fifo_q[rd_ptr_q].status;

`ifdef EV_TIMER_STATS_EN
    // Saturating per-status push counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ok_cnt      <= '0;
            stat_timeout_cnt <= '0;
            stat_orphan_cnt  <= '0;
        end else if (push) begin
            if (push_rec.status == ST_OK && stat_ok_cnt != 16'hFFFF)
                stat_ok_cnt <= stat_ok_cnt + 16'd1;
            if (push_rec.status == ST_TIMEOUT && stat_timeout_cnt != 16'hFFFF)
                stat_timeout_cnt <= stat_timeout_cnt + 16'd1;
            if (push_rec.status == ST_ORPHAN && stat_orphan_cnt != 16'hFFFF)
                stat_orphan_cnt <= stat_orphan_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_event_timestamper_mc.sv
// Randomized and directed bench for event_timestamper_mc against a queue-based reference model.
module tb_event_timestamper_mc;
    localparam int ID_W      = 3;
    localparam int TS_W      = 8;
    localparam int OUT_DEPTH = 4;
    localparam int TIMEOUT   = 40;
    localparam int N_ID      = 1 << ID_W;
    localparam int MASK      = (1 << TS_W) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic [ID_W-1:0] start_id = '0;
    logic            end_valid = 1'b0;
    logic            end_ready;
    logic [ID_W-1:0] end_id = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [ID_W-1:0] out_id;
    logic [TS_W-1:0] out_start_ts;
    logic [TS_W-1:0] out_end_ts;
    logic [TS_W-1:0] out_ts;
    logic [1:0]      out_status;
`ifdef EV_TIMER_STATS_EN
    logic [15:0]     stat_ok_cnt, stat_timeout_cnt, stat_orphan_cnt;
`endif

    event_timestamper_mc #(
        .ID_W(ID_W), .TS_W(TS_W), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_id(start_id),
        .end_valid(end_valid), .end_ready(end_ready), .end_id(end_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_start_ts(out_start_ts), .out_end_ts(out_end_ts), .out_ts(out_ts),
        .out_status(out_status)
`ifdef EV_TIMER_STATS_EN
        , .stat_ok_cnt(stat_ok_cnt), .stat_timeout_cnt(stat_timeout_cnt),
        .stat_orphan_cnt(stat_orphan_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int st;
        int en;
        int status;
    } rec_t;

    rec_t m_q[$];
    bit   m_act[N_ID];
    int   m_start[N_ID];
    int   m_cnt;
    int   m_scan;
    int   m_stat[3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < N_ID; i++) begin
            m_act[i]   = 1'b0;
            m_start[i] = 0;
        end
        m_cnt  = 0;
        m_scan = 0;
        for (int i = 0; i < 3; i++) m_stat[i] = 0;
    endtask

    task automatic model_push(int id, int st, int status);
        rec_t r;
        r.id = id; r.st = st; r.en = m_cnt; r.status = status;
        m_q.push_back(r);
        m_stat[status]++;
    endtask

    // Compare DUT against model state, then advance the model across the coming edge.
    task automatic model_step();
        bit exp_sr, full, s_hs, e_hs;
        int sid, eid;
        sid    = int'(start_id);
        eid    = int'(end_id);
        exp_sr = !(end_valid && sid == eid);
        full   = (m_q.size() == OUT_DEPTH);
        check_eq("start_ready", 32'(start_ready), 32'(exp_sr));
        check_eq("end_ready", 32'(end_ready), 32'(!full));
        check_eq("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_eq("out_id", 32'(out_id), 32'(m_q[0].id));
            check_eq("out_start_ts", 32'(out_start_ts), 32'(m_q[0].st));
            check_eq("out_end_ts", 32'(out_end_ts), 32'(m_q[0].en));
            check_eq("out_ts", 32'(out_ts), 32'((m_q[0].en - m_q[0].st) & MASK));
            check_eq("out_status", 32'(out_status), 32'(m_q[0].status));
        end
        s_hs = start_valid && exp_sr;
        e_hs = end_valid && !full;
        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        if (e_hs) begin
            if (m_act[eid]) model_push(eid, m_start[eid], 0);
            else            model_push(eid, 0, 2);
            m_act[eid] = 1'b0;
        end else if (!full) begin
            if (!(s_hs && sid == m_scan) && m_act[m_scan] &&
                ((m_cnt - m_start[m_scan]) & MASK) >= TIMEOUT) begin
                model_push(m_scan, m_start[m_scan], 1);
                m_act[m_scan] = 1'b0;
            end
            m_scan = (m_scan + 1) % N_ID;
        end
        if (s_hs) begin
            m_act[sid]   = 1'b1;
            m_start[sid] = m_cnt;
        end
        m_cnt = (m_cnt + 1) & MASK;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit sv, int sid, bit ev, int eid, bit ordy);
        start_valid = sv;
        start_id    = ID_W'(sid);
        end_valid   = ev;
        end_id      = ID_W'(eid);
        out_ready   = ordy;
    endtask

    task automatic idle(int n);
        drive(0, 0, 0, 0, 1);
        repeat (n) cycle();
    endtask

    task automatic wait_cnt(int target);
        int budget;
        budget = 300;
        drive(0, 0, 0, 0, 1);
        while (m_cnt != target && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) check_eq("wait_cnt_budget", 32'(m_cnt), 32'(target));
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic do_reset(int edges);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_id", 32'(out_id), 0);
        check_eq("rst_out_start", 32'(out_start_ts), 0);
        check_eq("rst_out_end", 32'(out_end_ts), 0);
        check_eq("rst_out_ts", 32'(out_ts), 0);
        check_eq("rst_out_status", 32'(out_status), 0);
        check_eq("rst_start_ready", 32'(start_ready), 0);
        check_eq("rst_end_ready", 32'(end_ready), 0);
        repeat (edges) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int cap, hid, hst, budget;
        bit found;
        model_reset();
        do_reset(4);

        // Basic path: start id 3 at cnt 5, end at cnt 11.
        wait_cnt(5);
        drive(1, 3, 0, 0, 1);
        cycle();
        wait_cnt(11);
        drive(0, 0, 1, 3, 1);
        cycle();
        check_eq("basic_valid", 32'(out_valid), 1);
        check_eq("basic_id", 32'(out_id), 3);
        check_eq("basic_start", 32'(out_start_ts), 5);
        check_eq("basic_end", 32'(out_end_ts), 11);
        check_eq("basic_ts", 32'(out_ts), 6);
        check_eq("basic_status", 32'(out_status), 0);
        idle(2);

        // Out-of-order burst.
        for (int i = 0; i < 3; i++) begin
            drive(1, i, 0, 0, 1);
            cycle();
        end
        drive(0, 0, 1, 1, 1); cycle();
        drive(0, 0, 1, 0, 1); cycle();
        drive(0, 0, 1, 2, 1); cycle();
        idle(3);
        check_eq("burst_empty", 32'(out_valid), 0);

        // Collision: end wins, start retries next cycle.
        drive(1, 5, 0, 0, 1);
        cycle();
        idle(2);
        drive(1, 5, 1, 5, 1);
        #1;
        check_eq("coll_start_ready", 32'(start_ready), 0);
        cycle();
        check_eq("coll_end_status", 32'(out_status), 0);
        drive(1, 5, 0, 0, 1);
        cap = m_cnt;
        cycle();
        idle(3);
        drive(0, 0, 1, 5, 1);
        cycle();
        check_eq("coll_new_start", 32'(out_start_ts), 32'(cap));
        idle(2);

        // Backpressure: fill FIFO with out_ready low.
        for (int i = 0; i < 5; i++) begin
            drive(1, i, 0, 0, 0);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, i, 0);
            cycle();
        end
        drive(0, 0, 1, 4, 0);
        #1;
        check_eq("bp_full_ready", 32'(end_ready), 0);
        check_eq("bp_head", 32'(out_id), 0);
        hid = int'(out_id);
        hst = int'(out_start_ts);
        repeat (3) cycle();
        check_eq("bp_stable_id", 32'(out_id), 32'(hid));
        check_eq("bp_stable_start", 32'(out_start_ts), 32'(hst));
        drive(0, 0, 1, 4, 1);
        cycle();
        check_eq("bp_after_pop_ready", 32'(end_ready), 1);
        cycle();
        idle(6);
        check_eq("bp_drained", 32'(out_valid), 0);

        // Timeout on id 6 started at cnt 20.
        wait_cnt(20);
        drive(1, 6, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 1);
        found  = 1'b0;
        budget = 80;
        while (!found && budget > 0) begin
            cycle();
            budget--;
            if (out_valid) found = 1'b1;
        end
        check_eq("to_found", 32'(found), 1);
        check_eq("to_id", 32'(out_id), 6);
        check_eq("to_start", 32'(out_start_ts), 20);
        check_eq("to_status", 32'(out_status), 1);
        check_eq("to_ts_range", 32'(out_ts >= 8'd40 && out_ts <= 8'd48), 1);
        idle(2);

        // Orphan end on inactive id 7.
        drive(0, 0, 1, 7, 1);
        cap = m_cnt;
        cycle();
        check_eq("orph_id", 32'(out_id), 7);
        check_eq("orph_start", 32'(out_start_ts), 0);
        check_eq("orph_end", 32'(out_end_ts), 32'(cap));
        check_eq("orph_status", 32'(out_status), 2);
        idle(2);

        // Counter wrap: start at 250, end at 4.
        wait_cnt(250);
        drive(1, 1, 0, 0, 1);
        cycle();
        wait_cnt(4);
        drive(0, 0, 1, 1, 1);
        cycle();
        check_eq("wrap_start", 32'(out_start_ts), 250);
        check_eq("wrap_end", 32'(out_end_ts), 4);
        check_eq("wrap_ts", 32'(out_ts), 10);
        idle(2);

        // Randomized traffic with a mid-run asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, N_ID - 1)),
                  ($urandom_range(0, 9) < 3), int'($urandom_range(0, N_ID - 1)),
                  ($urandom_range(0, 3) != 0));
            if (i == 1500) do_reset(2);
            cycle();
        end
        idle(12);
        check_eq("final_empty", 32'(out_valid), 0);

`ifdef EV_TIMER_STATS_EN
        check_eq("stat_ok", 32'(stat_ok_cnt), 32'(m_stat[0]));
        check_eq("stat_timeout", 32'(stat_timeout_cnt), 32'(m_stat[1]));
        check_eq("stat_orphan", 32'(stat_orphan_cnt), 32'(m_stat[2]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
